// File: rtl/led_run_pkg.sv
// led_run_pkg: shared FSM encoding, widths and default timing for the LED run controller
package led_run_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_e;
   localparam int SPEED_W      = 2;
   localparam int DEB_CYC_DEF  = 20;
   localparam int BASE_DIV_DEF = 50;
endpackage

// File: rtl/led_run_ctrl_if.sv
// led_run_ctrl_if: raw keys in, runner control out
interface led_run_ctrl_if;
   import led_run_pkg::*;
   logic               key_start_n;
   logic               key_dir_n;
   logic               key_speed_n;
   logic               step_en;
   logic               mode;
   logic [SPEED_W-1:0] speed;
   logic               running;
   modport master (output key_start_n, key_dir_n, key_speed_n, input step_en, mode, speed, running);
   modport slave  (input key_start_n, key_dir_n, key_speed_n, output step_en, mode, speed, running);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronize a raw active-low key, debounce it and emit a one-cycle press pulse
module key_debounce #(
   parameter int DEB_CYC = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DEB_CYC + 1);
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, press_q, press_d, diff, last;
   // stability counter runs only while the synchronized key disagrees with the accepted level
   always_comb begin
      sync_d  = {sync_q[0], key_n};
      diff    = sync_q[1] ^ level_q;
      last    = cnt_q == CW'(DEB_CYC - 1);
      level_d = level_q ^ (diff & last);
      cnt_d   = (diff && !last) ? cnt_q + 1'b1 : '0;
      press_d = level_q & ~level_d;
   end
   // synchronizer and level preset high so a key held through reset is still seen as a fresh press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         level_q <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end
   assign press = press_q;
endmodule

// File: rtl/led_run_ctrl.sv
// led_run_ctrl: start/pause FSM, direction and speed control, and step prescaler for an LED runner
module led_run_ctrl
   import led_run_pkg::*;
#(
   parameter int DEB_CYC  = DEB_CYC_DEF,
   parameter int BASE_DIV = BASE_DIV_DEF
) (
   input logic           clk,
   input logic           rst_n,
   led_run_ctrl_if.slave bus
);
   localparam int PW = $clog2((BASE_DIV << 3) + 1);
   state_e             state_q, state_d;
   logic [PW-1:0]      pre_q, pre_d, period_m1;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic               mode_q, mode_d, step_q, step_d, run_q, run_d;
   logic               start_p, dir_p, speed_p, cnt_en, tc;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_start (.clk(clk), .rst_n(rst_n), .key_n(bus.key_start_n), .press(start_p));
   key_debounce #(.DEB_CYC(DEB_CYC)) u_dir   (.clk(clk), .rst_n(rst_n), .key_n(bus.key_dir_n),   .press(dir_p));
   key_debounce #(.DEB_CYC(DEB_CYC)) u_speed (.clk(clk), .rst_n(rst_n), .key_n(bus.key_speed_n), .press(speed_p));

   // next state and prescaler; counting is frozen on the edge that leaves or enters RUN, and a speed press beats terminal count
   always_comb begin
      state_d   = !start_p ? state_q : (state_q == RUN) ? PAUSE : RUN;
      period_m1 = (PW'(BASE_DIV) << speed_q) - 1'b1;
      cnt_en    = (state_q == RUN) && (state_d == RUN);
      tc        = pre_q == period_m1;
      step_d    = cnt_en && tc && !speed_p;
      pre_d     = speed_p ? '0 : !cnt_en ? pre_q : tc ? '0 : pre_q + 1'b1;
      speed_d   = speed_q + SPEED_W'(speed_p);
      mode_d    = mode_q ^ dir_p;
      run_d     = state_d == RUN;
   end
   // all control state and outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pre_q   <= '0;
         speed_q <= '0;
         mode_q  <= 1'b0;
         step_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         speed_q <= speed_d;
         mode_q  <= mode_d;
         step_q  <= step_d;
         run_q   <= run_d;
      end
   end

   assign bus.step_en = step_q;
   assign bus.mode    = mode_q;
   assign bus.speed   = speed_q;
   assign bus.running = run_q;
endmodule

// File: tb/tb_led_run_ctrl.sv
// tb_led_run_ctrl: directed and random key stimulus checked cycle by cycle against a behavioural model
module tb_led_run_ctrl;
   localparam int DEB  = 4;
   localparam int BASE = 5;
   localparam int L    = DEB + 2;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   bit [2:0] kn = 3'b111;
   int       tests = 0;
   int       fails = 0;

   led_run_ctrl_if ifc ();
   assign ifc.key_start_n = kn[0];
   assign ifc.key_dir_n   = kn[1];
   assign ifc.key_speed_n = kn[2];

   led_run_ctrl #(.DEB_CYC(DEB), .BASE_DIV(BASE)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

   always #5 clk = ~clk;

   // model: 0 idle, 1 run, 2 pause; phase = cycles of the current step period already spent in RUN
   int m_state, m_phase, m_speed;
   bit m_mode, m_step;
   bit lev [3];
   bit prs [3];
   bit hist[3][$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_phase = 0; m_speed = 0; m_mode = 0; m_step = 0;
      for (int i = 0; i < 3; i++) begin
         lev[i] = 1; prs[i] = 0;
         hist[i].delete();
         repeat (L) hist[i].push_back(1'b1);
      end
   endtask

   // a key level flips once its last DEB synchronized samples (raw delayed two cycles) all disagree with it
   task automatic model_edge();
      bit nl[3];
      bit flip;
      int ns, p;
      for (int i = 0; i < 3; i++) begin
         hist[i].push_back(kn[i]);
         void'(hist[i].pop_front());
         flip = 1;
         for (int j = 0; j < DEB; j++) if (hist[i][j] == lev[i]) flip = 0;
         nl[i] = flip ? !lev[i] : lev[i];
      end
      p  = BASE * (2 ** m_speed);
      ns = !prs[0] ? m_state : (m_state == 1) ? 2 : 1;
      m_step = 0;
      if (prs[2]) begin
         m_speed = (m_speed + 1) % 4;
         m_phase = 0;
      end else if (m_state == 1 && ns == 1) begin
         m_phase++;
         if (m_phase == p) begin
            m_step  = 1;
            m_phase = 0;
         end
      end
      if (prs[1]) m_mode = !m_mode;
      m_state = ns;
      for (int i = 0; i < 3; i++) begin
         prs[i] = lev[i] && !nl[i];
         lev[i] = nl[i];
      end
   endtask

   task automatic check_outputs();
      chk("step_en", ifc.step_en, m_step);
      chk("mode", ifc.mode, m_mode);
      chk("speed", ifc.speed, m_speed);
      chk("running", ifc.running, m_state == 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      chk("rst_step_en", ifc.step_en, 0);
      chk("rst_running", ifc.running, 0);
      chk("rst_mode", ifc.mode, 0);
      chk("rst_speed", ifc.speed, 0);
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
   endtask

   task automatic press(input int k, input int hold);
      kn[k] = 1'b0;
      repeat (hold) tick();
      kn[k] = 1'b1;
      repeat (DEB + 3) tick();
   endtask

   // wait so that a key driven low now produces its press in a cycle whose phase equals target
   task automatic wait_phase(input int target);
      int p, w, n;
      p = BASE * (2 ** m_speed);
      w = ((target - L) % p + p) % p;
      n = 0;
      while ((m_phase != w || m_state != 1) && n < 1000) begin
         tick();
         n++;
      end
      chk("wait_phase_timeout", n < 1000, 1);
   endtask

   task automatic measure_period(output int per);
      int n;
      n = 0;
      while (!ifc.step_en && n < 2000) begin
         tick();
         n++;
      end
      per = 0;
      do begin
         tick();
         per++;
      end while (!ifc.step_en && per < 2000);
   endtask

   initial begin
      int n, sc, per;
      int cd[3];
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      chk("init_step_en", ifc.step_en, 0);
      chk("init_running", ifc.running, 0);
      rst_n = 1'b1;
      sc = 0;
      repeat (100) begin
         tick();
         sc += ifc.step_en;
      end
      chk("idle_no_step", sc, 0);
      kn[0] = 1'b0;
      repeat (3) tick();
      kn[0] = 1'b1;
      repeat (12) tick();
      chk("glitch_ignored", ifc.running, 0);
      kn[0] = 1'b0;
      n = 0;
      while (!ifc.running && n < 100) begin
         tick();
         n++;
      end
      sc = 0;
      while (!ifc.step_en && sc < 100) begin
         tick();
         sc++;
      end
      chk("first_step_gap", sc, BASE);
      kn[0] = 1'b1;
      repeat (DEB + 3) tick();
      chk("single_press_running", ifc.running, 1);
      measure_period(per);
      chk("period_s0", per, BASE);
      wait_phase(BASE - 1);
      kn[2] = 1'b0;
      repeat (L + 1) tick();
      chk("clear_beats_tc", ifc.step_en, 0);
      repeat (2) tick();
      kn[2] = 1'b1;
      repeat (DEB + 3) tick();
      measure_period(per);
      chk("period_s1", per, 2 * BASE);
      for (int s = 2; s <= 4; s++) begin
         repeat ($urandom_range(0, 7)) tick();
         press(2, L + 2);
         measure_period(per);
         chk("period_after_speed", per, BASE * (2 ** (s % 4)));
      end
      wait_phase(0);
      kn[1] = 1'b0;
      repeat (L) tick();
      chk("dir_coincident_step", ifc.step_en, 1);
      chk("dir_old_mode", ifc.mode, 0);
      tick();
      chk("dir_new_mode", ifc.mode, 1);
      kn[1] = 1'b1;
      repeat (DEB + 3) tick();
      press(1, L + 2);
      chk("dir_second_press", ifc.mode, 0);
      wait_phase(2);
      kn[0] = 1'b0;
      repeat (L + 1) tick();
      chk("paused", ifc.running, 0);
      kn[0] = 1'b1;
      sc = 0;
      repeat (50) begin
         tick();
         sc += ifc.step_en;
      end
      chk("pause_no_step", sc, 0);
      kn[0] = 1'b0;
      n = 0;
      while (!ifc.running && n < 100) begin
         tick();
         n++;
      end
      sc = 0;
      while (!ifc.step_en && sc < 100) begin
         tick();
         sc++;
      end
      chk("resume_gap", sc, 3);
      kn[0] = 1'b1;
      repeat (DEB + 3) tick();
      press(1, L + 2);
      press(2, L + 2);
      n = 0;
      while (!(m_phase == 3 && m_state == 1) && n < 1000) begin
         tick();
         n++;
      end
      do_reset();
      sc = 0;
      repeat (30) begin
         tick();
         sc += ifc.step_en + ifc.running;
      end
      chk("idle_after_reset", sc, 0);
      kn[0] = 1'b0;
      tick();
      do_reset();
      repeat (DEB + 6) tick();
      chk("held_through_reset", ifc.running, 1);
      kn[0] = 1'b1;
      repeat (DEB + 3) tick();
      for (int i = 0; i < 3; i++) cd[i] = $urandom_range(1, 14);
      repeat (3000) begin
         for (int i = 0; i < 3; i++) begin
            if (cd[i] == 0) begin
               kn[i] = !kn[i];
               cd[i] = kn[i] ? $urandom_range(1, 30) : $urandom_range(1, 14);
            end else cd[i]--;
         end
         if ($urandom_range(0, 799) == 0) do_reset();
         tick();
      end
      kn = 3'b111;
      repeat (DEB + 3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/led_run_ctrl.md
LED_RUN_CTRL -- requirements
Module: led_run_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 20, is the number of consecutive stable cycles required to accept a key level.
REQ-002 Parameter BASE_DIV, default 50, is the step period in clk cycles at speed 0; minimum 2.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port key_start_n  input  1  raw start/pause button; active-low; asynchronous to clk.
REQ-006 Port key_dir_n  input  1  raw direction button; active-low; asynchronous to clk.
REQ-007 Port key_speed_n  input  1  raw speed button; active-low; asynchronous to clk.
REQ-008 Port step_en  output  1  one-cycle pulse; the LED runner advances one position per pulse.
REQ-009 Port mode  output  1  direction to the runner: 0 = shift left (bit0 toward bit7), 1 = shift right.
REQ-010 Port speed  output  2  current speed level 0..3.
REQ-011 Port running  output  1  high while the FSM is in RUN.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer, preset to 1, before any other use.
REQ-013 A key's debounced level SHALL change only after the synchronized input has differed from it for DEB_CYC consecutive cycles; any shorter excursion resets the stability count.
REQ-014 A press SHALL be a single-cycle pulse on the debounced level's 1->0 transition; a held key yields exactly one press; release yields none.
REQ-015 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-016 A start press SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN; there are no other transitions except reset.
REQ-017 A dir press SHALL toggle mode in any state, effective on the clock edge after the press.
REQ-018 A speed press SHALL increment speed modulo 4 (3->0) in any state and SHALL clear the prescaler.
REQ-019 The step period SHALL be BASE_DIV << speed cycles: 50, 100, 200 or 400 at the defaults.
REQ-020 The prescaler SHALL count only in RUN, hold its value in PAUSE, and be zero in IDLE.
REQ-021 step_en SHALL assert for one cycle when the prescaler equals period-1 in RUN; the prescaler then wraps to 0.
REQ-022 The first step_en after IDLE->RUN SHALL occur period cycles after the transition edge.
REQ-023 On PAUSE->RUN, counting SHALL resume from the held value, so the remaining cycles of the interrupted period complete first.
REQ-024 Simultaneous speed press and terminal count: the clear wins, step_en SHALL stay 0, and the new period starts from 0.
REQ-025 Simultaneous dir press and step_en: step_en SHALL assert with the old mode presented; the new mode applies from the next cycle.
REQ-026 Simultaneous start and speed presses SHALL both take effect in the same cycle.
REQ-027 step_en SHALL never assert in IDLE or PAUSE.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state IDLE, mode 0, speed 0, step_en 0 and running 0, clear the prescaler and debounce counters, set synchronizer and debounced levels to 1, and clear the press pulses.
REQ-030 Reset mid-RUN SHALL abort the current period with no step_en; after release the block SHALL wait for a new start press.
REQ-031 A key held low through reset release SHALL be accepted as a press once it has been stable for DEB_CYC cycles.

Structure
REQ-032 Package led_run_pkg SHALL hold the FSM state encoding, the speed width (2), and the default DEB_CYC and BASE_DIV values.
REQ-033 Synchronizer, debounce and press detection SHALL be a sub-module key_debounce, instantiated three times.
REQ-034 The prescaler width SHALL be sized for BASE_DIV << 3 without overflow.

Verification (DEB_CYC=4, BASE_DIV=5)
REQ-035 Reset, all keys high -> state IDLE, step_en/running/mode/speed = 0; no step_en over 100 cycles.
REQ-036 key_start_n low for 3 cycles, then high -> no press, state IDLE; low for 12 cycles -> exactly one press, running=1, then step_en every 5 cycles, first 5 cycles after entry.
REQ-037 In RUN, speed presses 1, 2, 3, 4 -> step_en period 10, 20, 40, then 5 (wrap); no step_en in a cycle where the clear coincides with terminal count.
REQ-038 In RUN, start press at prescaler=2 -> PAUSE, prescaler holds at 2, no step_en for 50 cycles; second start press -> first step_en 3 cycles after the RUN edge.
REQ-039 Dir press coinciding with step_en -> that pulse carries mode=0, mode=1 from the next cycle; second dir press -> mode=0.
REQ-040 rst_n low for one cycle mid-RUN at prescaler=3 -> outputs per REQ-029 immediately, no step_en, IDLE after release.
